// File: rtl/unpack_expand_12_16.sv
// unpack_expand_12_16: unpacks 4 LSB-first 12-bit samples from every 3 bus words and expands each to 16-bit signed
module unpack_expand_12_16 #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             mid_en,
   input  logic [15:0]      in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [15:0]      out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [CNT_W-1:0] sample_cnt
);
   typedef enum logic [1:0] {PH0, PH1, PH2, PH3} state_t;
   state_t      r_state, w_state_nxt;
   logic [11:0] r_res, w_res_nxt, w_sample;
   logic        w_space, w_acc, w_load;
   assign w_space  = !out_valid | out_ready;
   assign in_ready = !flush & (r_state != PH3) & w_space;
   assign w_acc    = in_valid & in_ready;
   assign w_load   = !flush & w_space & (w_acc | (r_state == PH3));
   // PH3 drains the complete sample left in the residue without consuming a word
   always_comb begin
      w_state_nxt = r_state;
      w_res_nxt   = r_res;
      w_sample    = r_res;
      case (r_state)
         PH0: begin
            w_sample = in_data[11:0];
            if (w_acc) begin
               w_state_nxt = PH1;
               w_res_nxt   = {8'h00, in_data[15:12]};
            end
         end
         PH1: begin
            w_sample = {in_data[7:0], r_res[3:0]};
            if (w_acc) begin
               w_state_nxt = PH2;
               w_res_nxt   = {4'h0, in_data[15:8]};
            end
         end
         PH2: begin
            w_sample = {in_data[3:0], r_res[7:0]};
            if (w_acc) begin
               w_state_nxt = PH3;
               w_res_nxt   = in_data[15:4];
            end
         end
         default: begin
            if (w_load) begin
               w_state_nxt = PH0;
               w_res_nxt   = '0;
            end
         end
      endcase
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= PH0;
         r_res   <= '0;
      end else if (flush) begin
         r_state <= PH0;
         r_res   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_res   <= w_res_nxt;
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_data  <= '0;
         out_valid <= 1'b0;
      end else begin
         if (w_load) out_data <= {w_sample, mid_en ? 4'h8 : 4'h0};
         out_valid <= w_load | (out_valid & !out_ready & !flush);
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sample_cnt <= '0;
      else if (out_valid & out_ready) sample_cnt <= sample_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
   end
endmodule
